stream_to_ram_wr: RTL and testbench

STREAM_TO_RAM_WR -- requirements
Module: stream_to_ram_wr

---
 rtl/stream_to_ram_wr.sv | 122 ++++++++++++
 tb/tb_stream_to_ram_wr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_ram_wr.sv
// Byte stream to ping-pong RAM writer: fills one half of a RAM at a time and
// hands each committed bank to a reader, stalling while both banks are full.
module stream_to_ram_wr #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic                  buf_done,
  output logic                  buf_sel,
  output logic [ADDR_WIDTH-1:0] buf_len,
  input  logic [1:0]            buf_release,
  output logic [1:0]            buf_full
);

  localparam int HALF_DEPTH = 2 ** (ADDR_WIDTH - 1);
  localparam int PW         = ADDR_WIDTH - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  wbank_q, wbank_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [1:0]            buf_full_q, buf_full_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  close_pend_q, close_pend_d;
  logic                  close_sel_q, close_sel_d;
  logic [ADDR_WIDTH-1:0] close_len_q, close_len_d;
  logic                  buf_done_q, buf_done_d;
  logic                  buf_sel_q, buf_sel_d;
  logic [ADDR_WIDTH-1:0] buf_len_q, buf_len_d;

  logic accept;
  logic close;

  assign s_ready = (state_q != ST_WAIT);
  assign accept  = s_valid && s_ready;
  assign close   = accept && (s_last || (ptr_q == PW'(HALF_DEPTH - 1)));

  // Handshake: a byte moves when s_valid and s_ready are both high on a
  // rising edge; s_ready depends only on registered state.
  always_comb begin
    state_d      = state_q;
    wbank_d      = wbank_q;
    ptr_d        = ptr_q;
    buf_full_d   = buf_full_q & ~buf_release;
    wr_en_d      = accept;
    wr_data_d    = accept ? s_data : wr_data_q;
    wr_addr_d    = accept ? {wbank_q, ptr_q} : wr_addr_q;
    close_pend_d = close;
    close_sel_d  = close ? wbank_q : close_sel_q;
    close_len_d  = close ? ({1'b0, ptr_q} + ADDR_WIDTH'(1)) : close_len_q;
    buf_done_d   = close_pend_q;
    buf_sel_d    = close_pend_q ? close_sel_q : buf_sel_q;
    buf_len_d    = close_pend_q ? close_len_q : buf_len_q;

    if (close) begin
      // Release is applied first so a close always leaves its own bank full.
      buf_full_d[wbank_q] = 1'b1;
      wbank_d             = ~wbank_q;
      ptr_d               = '0;
      state_d             = buf_full_d[wbank_d] ? ST_WAIT : ST_IDLE;
    end else if (accept) begin
      ptr_d   = ptr_q + PW'(1);
      state_d = ST_FILL;
    end else if ((state_q == ST_WAIT) && !buf_full_q[wbank_q]) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wbank_q      <= 1'b0;
      ptr_q        <= '0;
      buf_full_q   <= 2'b00;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      close_pend_q <= 1'b0;
      close_sel_q  <= 1'b0;
      close_len_q  <= '0;
      buf_done_q   <= 1'b0;
      buf_sel_q    <= 1'b0;
      buf_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      wbank_q      <= wbank_d;
      ptr_q        <= ptr_d;
      buf_full_q   <= buf_full_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      close_pend_q <= close_pend_d;
      close_sel_q  <= close_sel_d;
      close_len_q  <= close_len_d;
      buf_done_q   <= buf_done_d;
      buf_sel_q    <= buf_sel_d;
      buf_len_q    <= buf_len_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_addr  = wr_addr_q;
  assign buf_done = buf_done_q;
  assign buf_sel  = buf_sel_q;
  assign buf_len  = buf_len_q;
  assign buf_full = buf_full_q;

endmodule

// File: tb/tb_stream_to_ram_wr.sv
// Self-checking bench for stream_to_ram_wr: a reference model predicts every
// RAM write and bank commit, and a monitor compares them cycle by cycle.
module tb_stream_to_ram_wr;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int HD = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          buf_done;
  logic          buf_sel;
  logic [AW-1:0] buf_len;
  logic [1:0]    buf_release;
  logic [1:0]    buf_full;

  stream_to_ram_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .buf_done    (buf_done),
    .buf_sel     (buf_sel),
    .buf_len     (buf_len),
    .buf_release (buf_release),
    .buf_full    (buf_full)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  // {cycle[31:0], addr[9:0], data[7:0]} and {cycle[31:0], sel, len[9:0]}
  logic [49:0] wr_exp_q[$];
  logic [42:0] done_exp_q[$];
  logic [AW-1:0] last_addr = '0;

  int         m_ptr;
  logic       m_wbank;
  logic [1:0] m_full;
  int         m_state; // 0 idle, 1 fill, 2 wait

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [49:0] we;
  logic [42:0] de;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      we = (wr_exp_q.size() != 0) ? wr_exp_q[0] : '0;
      if (wr_exp_q.size() != 0 && we[49:18] == 32'(cyc)) begin
        void'(wr_exp_q.pop_front());
        check_eq("wr_en", wr_en, 1'b1);
        check_eq("wr_addr", wr_addr, we[17:8]);
        check_eq("wr_data", wr_data, we[7:0]);
        last_addr = we[17:8];
      end else begin
        check_eq("wr_en_idle", wr_en, 1'b0);
        check_eq("wr_addr_hold", wr_addr, last_addr);
      end
      de = (done_exp_q.size() != 0) ? done_exp_q[0] : '0;
      if (done_exp_q.size() != 0 && de[42:11] == 32'(cyc)) begin
        void'(done_exp_q.pop_front());
        check_eq("buf_done", buf_done, 1'b1);
        check_eq("buf_sel", buf_sel, de[10]);
        check_eq("buf_len", buf_len, de[9:0]);
      end else begin
        check_eq("buf_done_idle", buf_done, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic [1:0] rel);
    logic [1:0] fn;
    logic       acc;
    s_valid     = v;
    s_data      = d;
    s_last      = l;
    buf_release = rel;
    @(negedge clk);
    check_eq("s_ready", s_ready, (m_state != 2));
    check_eq("buf_full", buf_full, m_full);
    acc = v && (m_state != 2);
    fn  = m_full & ~rel;
    if (acc) begin
      wr_exp_q.push_back({32'(cyc + 1), m_wbank, 9'(m_ptr), d});
      if (l || m_ptr == HD - 1) begin
        fn[m_wbank] = 1'b1;
        done_exp_q.push_back({32'(cyc + 2), m_wbank, 10'(m_ptr + 1)});
        m_wbank = ~m_wbank;
        m_ptr   = 0;
        m_state = fn[m_wbank] ? 2 : 0;
      end else begin
        m_ptr++;
        m_state = 1;
      end
    end else if (m_state == 2 && !m_full[m_wbank]) begin
      m_state = 0;
    end
    m_full = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    buf_release = 2'b00;
    #2;
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_wr_data", wr_data, 8'h00);
    check_eq("rst_wr_addr", wr_addr, 10'h000);
    check_eq("rst_buf_done", buf_done, 1'b0);
    check_eq("rst_buf_sel", buf_sel, 1'b0);
    check_eq("rst_buf_len", buf_len, 10'h000);
    check_eq("rst_buf_full", buf_full, 2'b00);
    check_eq("rst_s_ready", s_ready, 1'b1);
    wr_exp_q.delete();
    done_exp_q.delete();
    last_addr = '0;
    m_ptr     = 0;
    m_wbank   = 1'b0;
    m_full    = 2'b00;
    m_state   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    #3;
    do_reset();

    // Full bank 0 with a descending pattern, then one byte into bank 1.
    for (int i = 0; i < HD; i++) drive(1'b1, 8'(255 - i), 1'b0, 2'b00);
    drive(1'b1, 8'h5A, 1'b0, 2'b00);
    idle(3);

    // Short frame closes bank 0 early; next byte lands at 512.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), (i == 4), 2'b00);
    drive(1'b1, 8'hC3, 1'b0, 2'b00);
    idle(3);

    // Both banks full: stall, then release bank 0 and resume at address 0.
    do_reset();
    for (int i = 0; i < 2 * HD; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hEE, 1'b0, 2'b00);
    drive(1'b1, 8'hA1, 1'b0, 2'b01);
    drive(1'b1, 8'hA2, 1'b0, 2'b00);
    drive(1'b1, 8'hA3, 1'b0, 2'b00);
    idle(3);

    // Bank 1 closes while bank 0 is released in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(i), (i == 2), 2'b00);
    drive(1'b1, 8'h40, 1'b0, 2'b00);
    drive(1'b1, 8'h41, 1'b1, 2'b01);
    drive(1'b1, 8'h42, 1'b0, 2'b00);
    idle(3);

    // Releasing bank 1 while it is empty or filling is ignored.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(i + 7), (i == 2), 2'b00);
    drive(1'b0, 8'h00, 1'b0, 2'b10);
    drive(1'b1, 8'h77, 1'b0, 2'b10);
    drive(1'b0, 8'h00, 1'b1, 2'b10);
    drive(1'b1, 8'h78, 1'b1, 2'b00);
    idle(3);

    // Reset mid-fill discards the partial bank.
    do_reset();
    for (int i = 0; i < 300; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 2'b00);
    idle(1);
    do_reset();
    drive(1'b1, 8'h99, 1'b0, 2'b00);
    idle(3);

    // Random traffic with sporadic frame ends and releases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 60) == 0),
            {($urandom_range(0, 40) == 0), ($urandom_range(0, 40) == 0)});
    end
    idle(4);

    check_eq("wr_q_drained", 64'(wr_exp_q.size()), 64'd0);
    check_eq("done_q_drained", 64'(done_exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
